// File: rtl/johnson_seq_ctrl.sv
// ============================================================================
// johnson_seq_ctrl
// ----------------------------------------------------------------------------
// Run-length sequencer for a WIDTH-bit Johnson (twisted-ring) counter.
// The block owns the counter register. It starts a run of exactly `len`
// steps, can pause it or abort it, and decodes the current Johnson code
// into a one-hot phase vector.
//
// Parameters
//   WIDTH  Johnson register width; the sequence has 2*WIDTH codes.
//   CNT_W  width of the run-length input and remaining-step counter.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous active-low reset
//   start  in   1        begin a run (sampled only in IDLE or DONE)
//   len    in   CNT_W    steps in the run (sampled with an accepted start)
//   pause  in   1        level, freezes stepping while high
//   stop   in   1        level, aborts the run (beats pause and step)
//   jc     out  WIDTH    Johnson counter value
//   phase  out  2*WIDTH  one-hot decode of jc (phase[0] = all zeros)
//   rem    out  CNT_W    steps still to take in the current run
//   busy   out  1        high while running
//   done   out  1        one-cycle pulse when a run completes
//
// Build option
//   JOHNSON_CTRL_LOOP_EN  when defined, the final step of a run reloads the
//                         remaining count from `len` and keeps running;
//                         `done` becomes a registered flag pulsed after each
//                         final step. A reload value of zero ends the loop.
//                         When undefined, runs are single-shot and no reload
//                         logic exists.
// ============================================================================
module johnson_seq_ctrl #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     len,
    input  logic                 pause,
    input  logic                 stop,
    output logic [WIDTH-1:0]     jc,
    output logic [2*WIDTH-1:0]   phase,
    output logic [CNT_W-1:0]     rem,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   jc_q, jc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic               len_zero;
    logic               rem_is_one;
    logic [WIDTH-1:0]   jc_step;
    logic [CNT_W-1:0]   rem_dec;

    assign len_zero   = (len == '0);
    assign rem_is_one = (rem_q == CNT_W'(1));

    // Twisted-ring shift: feed back the inverted MSB into the LSB.
    assign jc_step = {jc_q[WIDTH-2:0], ~jc_q[WIDTH-1]};

    // Saturating decrement so rem can never wrap below zero.
    assign rem_dec = (rem_q != '0) ? (rem_q - CNT_W'(1)) : rem_q;

`ifdef JOHNSON_CTRL_LOOP_EN
    logic done_q, done_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        jc_d    = jc_q;
        rem_d   = rem_q;
`ifdef JOHNSON_CTRL_LOOP_EN
        done_d  = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // stop is irrelevant outside RUN, so start always wins here.
                if (start) begin
                    jc_d = '0;
                    if (len_zero) begin
                        // Zero-length run: complete immediately, no steps.
                        state_d = ST_DONE;
`ifdef JOHNSON_CTRL_LOOP_EN
                        done_d  = 1'b1;
`endif
                    end else begin
                        rem_d   = len;
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort: counter and remaining count are left visible.
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    jc_d  = jc_step;
                    rem_d = rem_dec;
                    if (rem_is_one) begin
`ifdef JOHNSON_CTRL_LOOP_EN
                        done_d = 1'b1;
                        if (len_zero) begin
                            state_d = ST_DONE;
                        end else begin
                            // Reload uses len as sampled on this final edge.
                            rem_d = len;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            jc_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            jc_q    <= jc_d;
            rem_q   <= rem_d;
        end
    end

`ifdef JOHNSON_CTRL_LOOP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = (state_q == ST_DONE);
`endif

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    // Code number idx in the Johnson sequence: for idx <= WIDTH the low idx
    // bits are ones; past that the ones drain out from the bottom, leaving
    // the top (2*WIDTH - idx) bits set.
    function automatic logic [WIDTH-1:0] code_at(input int idx);
        logic [WIDTH-1:0] code;
        for (int b = 0; b < WIDTH; b++) begin
            if (idx <= WIDTH) begin
                code[b] = (b < idx);
            end else begin
                code[b] = (b >= idx - WIDTH);
            end
        end
        return code;
    endfunction

    // Each phase bit is a full compare against its own code, so the decode
    // stays one-hot for every legal Johnson value.
    generate
        for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_phase
            assign phase[gi] = (jc_q == code_at(gi));
        end
    endgenerate

    assign jc   = jc_q;
    assign rem  = rem_q;
    assign busy = (state_q == ST_RUN);

endmodule
